// File: rtl/ac_store_queue_if.sv
// Store-queue bus: controller command port, memory write port, hazard lookup and status.
interface ac_store_queue_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [ADDR_W-1:0] chk_addr;
  logic              chk_hit;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;

  modport slave (
    input  st_valid, st_addr, st_data, mem_ack, chk_addr,
    output st_ready, mem_we, mem_addr, mem_wdata, chk_hit, count, empty, full
  );

  modport master (
    output st_valid, st_addr, st_data, mem_ack, chk_addr,
    input  st_ready, mem_we, mem_addr, mem_wdata, chk_hit, count, empty, full
  );
endinterface

// File: rtl/ac_store_queue.sv
// Write-side store buffer: FIFO of {addr, data} drained to data memory, with
// an address-hazard lookup over all pending entries.
module ac_store_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
) (
  input logic               clk,
  input logic               rst_n,
  ac_store_queue_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wp, rp;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  state_t           state, state_nxt;
  logic             is_empty, is_full;
  logic             push, pop;
  logic [DEPTH-1:0] hit_vec;

  assign push = bus.st_valid && bus.st_ready;
  assign pop  = !is_empty && bus.mem_ack;

  // state register (state mirrors cnt, kept in lockstep)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      state <= S_EMPTY;
    end else begin
      if (push) wp <= wp + PTR_W'(1);
      if (pop)  rp <= rp + PTR_W'(1);
      cnt   <= cnt_nxt;
      state <= state_nxt;
    end
  end

  // storage carries no reset; validity comes from the pointers and count
  always_ff @(posedge clk) begin
    if (push) mem_q[wp] <= '{addr: bus.st_addr, data: bus.st_data};
  end

  // next-state
  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + CNT_W'(1);
    else if (pop && !push) cnt_nxt = cnt - CNT_W'(1);
    state_nxt = S_PARTIAL;
    if (cnt_nxt == '0)                 state_nxt = S_EMPTY;
    else if (cnt_nxt == CNT_W'(DEPTH)) state_nxt = S_FULL;
  end

  // outputs
  always_comb begin
    is_empty = 1'b0;
    is_full  = 1'b0;
    case (state)
      S_EMPTY: is_empty = 1'b1;
      S_FULL:  is_full  = 1'b1;
      default: ;
    endcase
  end

  // entry i is pending when its distance from rp is below count
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    logic [PTR_W-1:0] ofs;
    assign ofs        = PTR_W'(i) - rp;
    assign hit_vec[i] = ({1'b0, ofs} < cnt) && (mem_q[i].addr == bus.chk_addr);
  end

  assign bus.st_ready  = !is_full && rst_n;
  assign bus.mem_we    = !is_empty;
  assign bus.mem_addr  = mem_q[rp].addr;
  assign bus.mem_wdata = mem_q[rp].data;
  assign bus.chk_hit   = |hit_vec;
  assign bus.count     = cnt;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
endmodule

// File: tb/tb_ac_store_queue.sv
// Directed bench for ac_store_queue; a negedge monitor checks every accepted
// memory write against a scoreboard filled by the stimulus.
module tb_ac_store_queue;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q [$];
  logic [ADDR_W+DATA_W-1:0] mon_e;

  ac_store_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  ac_store_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive a store that must be accepted at the next edge
  task automatic drive(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    exp_q.push_back({a, d});
  endtask

  always @(negedge clk) begin
    if (bus.mem_we && bus.mem_ack) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL stray_write: got addr %0h data %0h expected no write", bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("drain_addr", 32'(bus.mem_addr), 32'(mon_e[ADDR_W+DATA_W-1:DATA_W]));
        chk("drain_data", 32'(bus.mem_wdata), 32'(mon_e[DATA_W-1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.st_valid = 1'b1;
    bus.st_addr  = 12'h3FF;
    bus.st_data  = 16'hDEAD;
    bus.mem_ack  = 1'b0;
    bus.chk_addr = 12'h3FF;

    // reset / idle
    repeat (3) step();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_ready", 32'(bus.st_ready), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_hit", 32'(bus.chk_hit), 0);
    rst_n = 1'b1;
    bus.st_valid = 1'b0;
    #1;
    chk("rel_ready", 32'(bus.st_ready), 1);
    chk("rel_empty", 32'(bus.empty), 1);
    chk("rel_full", 32'(bus.full), 0);

    // single store; ack while empty is ignored
    bus.mem_ack = 1'b1;
    drive(12'h010, 16'hBEEF);
    step();
    bus.st_valid = 1'b0;
    chk("one_we", 32'(bus.mem_we), 1);
    chk("one_addr", 32'(bus.mem_addr), 32'h010);
    chk("one_data", 32'(bus.mem_wdata), 32'hBEEF);
    step();
    chk("one_empty", 32'(bus.empty), 1);
    chk("one_count", 32'(bus.count), 0);

    // fill / backpressure
    bus.mem_ack = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(12'h100 + 12'(i), 16'(i));
      step();
    end
    bus.st_valid = 1'b1;
    bus.st_addr  = 12'h105;
    bus.st_data  = 16'h0005;
    #1;
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_count", 32'(bus.count), 4);
    chk("fill_ready", 32'(bus.st_ready), 0);
    step();
    chk("hold_count", 32'(bus.count), 4);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("ack_count", 32'(bus.count), 3);
    chk("ack_ready", 32'(bus.st_ready), 1);
    drive(12'h105, 16'h0005);
    step();
    bus.st_valid = 1'b0;
    chk("refill_count", 32'(bus.count), 4);
    bus.mem_ack = 1'b1;
    repeat (4) step();
    chk("drain_empty", 32'(bus.empty), 1);

    // simultaneous push/pop at constant occupancy
    bus.mem_ack = 1'b0;
    drive(12'h200, 16'h0200);
    step();
    drive(12'h201, 16'h0201);
    step();
    bus.mem_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(12'h210 + 12'(k), 16'h0210 + 16'(k));
      step();
      chk("pp_count", 32'(bus.count), 2);
    end
    bus.st_valid = 1'b0;
    repeat (2) step();
    chk("pp_empty", 32'(bus.empty), 1);

    // hazard lookup
    bus.mem_ack = 1'b0;
    drive(12'h020, 16'hA020);
    step();
    drive(12'h021, 16'hA021);
    step();
    bus.st_valid = 1'b0;
    bus.chk_addr = 12'h021;
    #1 chk("haz_hit21", 32'(bus.chk_hit), 1);
    bus.chk_addr = 12'h022;
    #1 chk("haz_miss22", 32'(bus.chk_hit), 0);
    drive(12'h022, 16'hA022);
    #1 chk("haz_push_invis", 32'(bus.chk_hit), 0);
    step();
    bus.st_valid = 1'b0;
    chk("haz_hit22", 32'(bus.chk_hit), 1);
    bus.mem_ack  = 1'b1;
    bus.chk_addr = 12'h020;
    #1 chk("haz_pop_vis", 32'(bus.chk_hit), 1);
    repeat (3) step();
    bus.chk_addr = 12'h021;
    #1 chk("haz_after_pop", 32'(bus.chk_hit), 0);

    // reset mid-drain; the write acked on the reset edge still counts
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(12'h030 + 12'(i), 16'h0C00 + 16'(i));
      step();
    end
    bus.st_valid = 1'b0;
    chk("mid_count", 32'(bus.count), 3);
    rst_n = 1'b0;
    bus.mem_ack = 1'b1;
    step();
    exp_q.delete();
    rst_n = 1'b1;
    #1;
    chk("mid_rst_count", 32'(bus.count), 0);
    chk("mid_rst_we", 32'(bus.mem_we), 0);
    chk("mid_rst_empty", 32'(bus.empty), 1);
    repeat (3) step();
    chk("mid_still_empty", 32'(bus.mem_we), 0);
    bus.mem_ack = 1'b0;

    chk("scoreboard_left", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ac_store_queue.md
# ac_store_queue

Write-side store buffer between the accumulator and data memory. The control unit issues store commands (address + accumulator value), and the block queues them in a small FIFO. It then drains them to the data-memory write port under a valid/ack handshake, so the datapath never stalls on a slow memory write. An address-hazard lookup lets the controller hold a load whose address still has a pending store.

## Interface
- DATA_W, 16: store data width (matches accumulator width)
- ADDR_W, 12: data-memory address width
- DEPTH, 4: queue entries; power of two, 2..16

- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- st_valid  input  1  store command present
- st_ready  output  1  queue can accept a command this cycle
- st_addr  input  ADDR_W  store address
- st_data  input  DATA_W  store data (accumulator value)
- mem_we  output  1  head entry presented to memory
- mem_addr  output  ADDR_W  head entry address
- mem_wdata  output  DATA_W  head entry data
- mem_ack  input  1  memory accepts the presented write this cycle
- chk_addr  input  ADDR_W  load address to test for hazard
- chk_hit  output  1  some pending entry has address == chk_addr
- count  output  $clog2(DEPTH)+1  entries currently held
- empty  output  1  count == 0
- full  output  1  count == DEPTH

## Operation
- Storage: DEPTH-entry circular buffer of {addr, data}, with write pointer wp, read pointer rp (log2(DEPTH) bits, wrap modulo DEPTH) and occupancy counter count.
- Push: on st_valid && st_ready, write {st_addr, st_data} at wp and increment wp.
- st_ready = !full && rst_n. It is derived from registered count only. A pop in the same cycle does not make a full queue accept a push.
- Pop: on mem_we && mem_ack, increment rp.
- mem_we = !empty. mem_addr and mem_wdata show entry[rp] combinationally from storage. They are stable while mem_we is high and no ack is given.
- mem_ack while mem_we == 0 is ignored: no pointer or count change.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle (possible only when 0 < count < DEPTH): unchanged, both pointers advance
  - neither: hold
- Order: strict FIFO; writes reach memory in command order, including repeated writes to the same address.
- Hazard check: chk_hit = OR over valid entries (those between rp inclusive and wp exclusive, count entries) of (entry.addr == chk_addr). It is purely combinational on current state.
  - An entry being pushed this cycle is not yet visible.
  - An entry being popped this cycle is still visible.
- State machine (derived from count):
  - EMPTY (count == 0)
  - PARTIAL
  - FULL (count == DEPTH)
  - Transitions move by at most one step per cycle per the count rules above.
- Arithmetic: pointer wrap is natural modulo DEPTH. count never exceeds DEPTH and never underflows, by construction of st_ready and mem_we.

## Timing
- Reset (rst_n low at a rising edge): wp = rp = count = 0. Storage contents are don't-care.
- Values after reset:
  - st_ready = 0 while rst_n is low, 1 in the first cycle after release
  - mem_we = 0, chk_hit = 0, empty = 1, full = 0, count = 0
- Reset mid-operation discards all queued stores. A write in flight whose mem_ack coincides with the reset edge is still considered accepted by memory, but the queue state resets regardless.
- Latency: command pushed at edge N can present at mem_we in cycle N+1, when the queue was empty before the push. There is no combinational st_valid -> mem_we path.
- Throughput: one push and one pop per cycle sustained. Queue stays at constant occupancy with st_valid = mem_ack = 1.
- Backpressure: with mem_ack held 0, the queue fills in DEPTH cycles, then st_ready = 0. The first ack frees a slot, and st_ready rises in the following cycle.

## Test plan
- Reset/idle: hold rst_n = 0 for 3 cycles with st_valid = 1 -> count = 0, st_ready = 0, mem_we = 0. After release, st_ready = 1 and empty = 1.
- Single store: push {0x010, 0xBEEF}, mem_ack = 1 -> mem_we high the next cycle with mem_addr = 0x010, mem_wdata = 0xBEEF. The entry pops on that cycle and empty returns to 1.
- Fill/backpressure: mem_ack = 0, push 5 stores with data 0x0001..0x0005, DEPTH = 4 -> first 4 accepted, full = 1, fifth held with st_ready = 0. One ack pops 0x0001, then 0x0005 is accepted the next cycle. Drain order is 2, 3, 4, 5.
- Simultaneous push/pop: count = 2, st_valid = mem_ack = 1 for 8 cycles with incrementing data -> count stays 2. Pointers wrap twice, and memory sees the data in exact order.
- Hazard: queue holds addresses 0x020 and 0x021 -> chk_addr = 0x021 gives chk_hit = 1, chk_addr = 0x022 gives 0. After both pop, chk_addr = 0x021 gives 0. An address being pushed the same cycle gives 0.
- Reset mid-drain: 3 entries queued, rst_n = 0 for 1 cycle with mem_ack = 1 -> count = 0 and mem_we = 0 the next cycle. No stale entry appears afterwards.
